risc_toy_fetch_queue: RTL



---
 rtl/risc_toy_pkg.sv | 38 +++
 rtl/risc_toy_sync_fifo.sv | 52 +++++
 rtl/risc_toy_fetch_queue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/risc_toy_pkg.sv
// Shared definitions for the RISC_TOY core: default widths, opcodes and
// the fetch-unit FSM encoding.
package risc_toy_pkg;

  localparam int unsigned RT_AW = 30;
  localparam int unsigned RT_DW = 32;

  localparam logic [4:0] OP_ADDI = 5'd0;
  localparam logic [4:0] OP_ANDI = 5'd1;
  localparam logic [4:0] OP_ORI  = 5'd2;
  localparam logic [4:0] OP_MOVI = 5'd3;
  localparam logic [4:0] OP_ADD  = 5'd4;
  localparam logic [4:0] OP_SUB  = 5'd5;
  localparam logic [4:0] OP_NEG  = 5'd6;
  localparam logic [4:0] OP_NOT  = 5'd7;
  localparam logic [4:0] OP_AND  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_XOR  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd15;
  localparam logic [4:0] OP_BRL  = 5'd16;
  localparam logic [4:0] OP_J    = 5'd17;
  localparam logic [4:0] OP_JL   = 5'd18;
  localparam logic [4:0] OP_LD   = 5'd19;
  localparam logic [4:0] OP_ST   = 5'd20;
  localparam logic [4:0] OP_LDR  = 5'd21;
  localparam logic [4:0] OP_STR  = 5'd22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/risc_toy_sync_fifo.sv
// Synchronous FIFO with a clear input; head data reads as zero when empty.
module risc_toy_sync_fifo #(
  parameter int unsigned WIDTH = 62,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [PW:0]      cnt_q;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  // Pointer and occupancy bookkeeping; clear wins over push and pop.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage array; contents beyond the occupied range are don't-care.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/risc_toy_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one word per cycle to a
// fixed-latency memory, buffers responses and hands them to decode.
module risc_toy_fetch_queue
  import risc_toy_pkg::*;
#(
  parameter int unsigned   AW       = RT_AW,
  parameter int unsigned   DW       = RT_DW,
  parameter int unsigned   DEPTH    = 4,
  parameter int unsigned   IMEM_LAT = 1,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RSTN,
  output logic          IREQ,
  output logic [AW-1:0] IADDR,
  input  logic [DW-1:0] INSTR,
  input  logic          REDIR,
  input  logic [AW-1:0] REDIR_ADDR,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] OUT_INSTR,
  output logic [AW-1:0] OUT_PC
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned LW = $clog2(IMEM_LAT + 1);

  fetch_state_e         state_q, state_d;
  logic [AW-1:0]        pc_q, pc_d;
  logic [IMEM_LAT-1:0]  slot_v_q, slot_v_d;
  logic [AW-1:0]        slot_pc_q [IMEM_LAT];
  logic [LW-1:0]        inflight_count;
  logic [CW-1:0]        fifo_count;
  logic [CW:0]          outstanding;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [AW+DW-1:0]     fifo_head;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RSTN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; a redirect from any state takes one flush cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_FETCH;
      ST_FLUSH: state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
    if (REDIR) state_d = ST_FLUSH;
  end

  // FSM output: issue only while the buffered plus in-flight words leave room.
  always_comb begin
    outstanding = {1'b0, fifo_count} + (CW+1)'(inflight_count);
    IREQ        = (state_q == ST_FETCH) && (outstanding < (CW+1)'(DEPTH));
  end

  // PC next value: redirect target, else advance on issue (wraps naturally).
  always_comb begin
    pc_d = pc_q;
    if (REDIR)     pc_d = REDIR_ADDR;
    else if (IREQ) pc_d = pc_q + AW'(1);
  end

  // PC register.
  always_ff @(posedge CLK) begin
    if (!RSTN) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  assign IADDR = pc_q;

  // In-flight valid shift; a redirect squashes everything still in the memory.
  always_comb begin
    slot_v_d    = slot_v_q;
    slot_v_d[0] = IREQ;
    for (int unsigned i = 1; i < IMEM_LAT; i++) slot_v_d[i] = slot_v_q[i-1];
    if (REDIR) slot_v_d = '0;
  end

  // In-flight valid register.
  always_ff @(posedge CLK) begin
    if (!RSTN) slot_v_q <= '0;
    else       slot_v_q <= slot_v_d;
  end

  // In-flight address shift; data only, qualified by the valid bits.
  always_ff @(posedge CLK) begin
    slot_pc_q[0] <= IADDR;
    for (int unsigned i = 1; i < IMEM_LAT; i++) slot_pc_q[i] <= slot_pc_q[i-1];
  end

  // Number of requests awaiting a memory response.
  always_comb begin
    inflight_count = '0;
    for (int unsigned i = 0; i < IMEM_LAT; i++)
      inflight_count = inflight_count + LW'(slot_v_q[i]);
  end

  assign fifo_push = slot_v_q[IMEM_LAT-1] & ~REDIR;
  assign fifo_pop  = OUT_VALID & OUT_READY;

  risc_toy_sync_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rstn_i  (RSTN),
    .clr_i   (REDIR),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  ({slot_pc_q[IMEM_LAT-1], INSTR}),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign OUT_VALID = ~fifo_empty;
  assign OUT_PC    = fifo_head[DW +: AW];
  assign OUT_INSTR = fifo_head[DW-1:0];

endmodule
